bin2bcd_serial: RTL and testbench
=================================

# bin2bcd_serial

Sequential binary-to-BCD converter using the shift-add-3 (double-dabble) method, one bit per clock. It sits directly upstream of the BCD decoder stage. It accepts a binary word on a start pulse, converts it over DATA_W cycles, and exposes the packed BCD result. It then streams the digits most-significant first over a valid/ready handshake, one 4-bit digit per transfer, into the decoder's 4-bit `in` port.

## Interface
- DATA_W, 8: width of the binary input.
- DIGITS, 3: number of BCD digits. Must satisfy 10^DIGITS > 2^DATA_W − 1; the bench checks this at elaboration/time 0.
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset; asynchronous assert, active-low; one clock, single domain.
- start  input  1  request to convert bin_in; sampled only in IDLE.
- bin_in  input  DATA_W  binary operand, captured on the accepted start edge.
- busy  output  1  high from the start-accept edge until the done edge.
- bcd_out  output  4*DIGITS  packed BCD result; digit 0 at [3:0]; valid from EMIT entry until the next start.
- digit_valid  output  1  digit_out holds a valid digit.
- digit_ready  input  1  downstream accepts digit_out.
- digit_out  output  4  current digit, 0–9.
- digit_idx  output  $clog2(DIGITS)  position of digit_out; DIGITS−1 is the most-significant digit.
- done  output  1  one-cycle pulse after the last digit transfer.

## Operation
- Reset values: state IDLE, busy 0, done 0, digit_valid 0, digit_out 0, digit_idx 0, bcd_out 0, shift and bit counters 0.
- FSM states:
  - IDLE: start=1 loads bin_in into the shift register, clears the BCD register and bit counter, sets busy, and moves to CONVERT.
  - CONVERT: each cycle, first add 3 to every BCD digit ≥5, then shift {bcd, bin} left by 1.
    - The bit counter increments each cycle.
    - After the DATA_W-th shift, the next state is EMIT, with digit_idx = DIGITS−1 and digit_valid = 1.
  - EMIT: digit_out = bcd[digit_idx]. Transfer occurs on a clock edge where digit_valid & digit_ready.
    - On transfer with digit_idx > 0, decrement digit_idx.
    - On transfer with digit_idx = 0, clear digit_valid and busy, pulse done, and move to IDLE.
- Arithmetic:
  - Add-3 is applied per 4-bit digit before the shift, never after.
  - The carry out of the top digit is discarded; the parameter constraint guarantees it is always 0.
- No leading-zero suppression: all DIGITS digits are always emitted.

## Timing
- Start accepted at edge k: busy=1 after edge k. CONVERT covers edges k+1 … k+DATA_W. digit_valid=1 after edge k+DATA_W, which is DATA_W cycles of latency.
- With digit_ready tied high, one digit transfers per cycle. done is high for the cycle after edge k+DATA_W+DIGITS, and busy is low at the same time.
- Back-to-back: start may be asserted in the same cycle done is high. It is accepted because the state is IDLE.
- digit_out and digit_idx must stay stable while digit_valid=1 and digit_ready=0.
- digit_ready while digit_valid=0 has no effect.
- start while busy is ignored; no queueing, no error flag.
- bin_in changes after the accept edge have no effect.
- rst_n low at any point, mid-CONVERT or mid-EMIT, immediately forces the reset values without waiting for a clock edge. The partial result is discarded and no done pulse is produced.
- Release of rst_n is synchronous to clk at the system level; the first start is honoured at the first rising edge with rst_n high.

## Structure
- Package bcd_pkg:
  - DIGIT_W = 4.
  - FSM state localparams IDLE/CONVERT/EMIT, 2-bit encoding.
  - Function for the add-3 correction, shared with any later BCD arithmetic blocks.
- Sub-module bcd_add3: combinational 4-bit in, 4-bit out (in ≥5 ? in+3 : in). It is instantiated DIGITS times with a generate loop.
- Single register set; no FIFO. The downstream decoder connects digit_out directly to its 4-bit input.

## Test plan
- Reset then bin_in=8'd255, start pulse, digit_ready=1 -> digit_valid rises 8 cycles after the start edge. bcd_out=12'h255. Digits stream 2,5,5 with idx 2,1,0. done pulses once; busy is high for exactly 11 cycles.
- bin_in=0 -> bcd_out=12'h000, digits 0,0,0. bin_in=100 -> bcd_out=12'h100, digits 1,0,0.
- bin_in=42, digit_ready toggles 0,0,1,0,1,1 -> digits 0,4,2 are delivered exactly once each, and digit_out is stable during every stall.
- start re-asserted during CONVERT with bin_in=99 after an accepted 42 -> output is still 0,4,2. A start in the done cycle with bin_in=99 -> next output is 0,9,9.
- rst_n pulsed low mid-CONVERT (cycle 4) and again mid-EMIT after one transfer -> all outputs go to reset values asynchronously and no done pulse occurs. A subsequent start with bin_in=7 yields 0,0,7.
- Exhaustive sweep of 0–255 with ready=1 -> every bcd_out matches the decimal reference model, and every digit_out is ≤9.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD datapath blocks.
//   DIGIT_W : width of one BCD digit
//   state_t : converter FSM encoding (IDLE / CONVERT / EMIT, 2 bits)
//   add3()  : double-dabble correction, adds 3 to a digit of 5 or more so
//             that the following left shift carries correctly into the
//             next decimal position
package bcd_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    EMIT    = 2'd2
  } state_t;

  function automatic logic [DIGIT_W-1:0] add3(input logic [DIGIT_W-1:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Combinational add-3 correction for one BCD digit.
//   din  : BCD digit before correction
//   dout : din + 3 when din >= 5, otherwise din
module bcd_add3
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] din,
  output logic [DIGIT_W-1:0] dout
);

  assign dout = add3(din);

endmodule

// File: rtl/bin2bcd_serial.sv
// Serial binary-to-BCD converter (double dabble, one bit per clock) with a
// digit-stream output, most-significant digit first, over valid/ready.
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : convert bin_in (honoured only while idle)
//   bin_in      : binary operand, captured when start is accepted
//   busy        : conversion or digit streaming in progress
//   bcd_out     : packed BCD result, digit 0 in [3:0]
//   digit_valid : digit_out / digit_idx carry a digit
//   digit_ready : downstream accepts the current digit
//   digit_out   : current digit, 0-9
//   digit_idx   : position of digit_out (DIGITS-1 = most significant)
//   done        : one-cycle pulse after the last digit transfer
module bin2bcd_serial
  import bcd_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DIGITS = 3,
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [DATA_W-1:0]         bin_in,
  output logic                      busy,
  output logic [DIGIT_W*DIGITS-1:0] bcd_out,
  output logic                      digit_valid,
  input  logic                      digit_ready,
  output logic [DIGIT_W-1:0]        digit_out,
  output logic [IDX_W-1:0]          digit_idx,
  output logic                      done
);

  localparam int BCD_W = DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(DATA_W + 1);

  state_t              state_reg, state_next;
  logic [DATA_W-1:0]   bin_reg, bin_next;
  logic [BCD_W-1:0]    bcd_reg, bcd_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [IDX_W-1:0]    idx_reg, idx_next;
  logic                valid_reg, valid_next;
  logic                busy_reg, busy_next;
  logic                done_reg, done_next;

  logic [BCD_W-1:0]        bcd_adj;
  logic [BCD_W+DATA_W-1:0] shift_next;

  // Correction is applied to every digit before the shift.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (bcd_reg[gi*DIGIT_W +: DIGIT_W]),
      .dout (bcd_adj[gi*DIGIT_W +: DIGIT_W])
    );
  end

  // The bit leaving the top digit is dropped by the shift; the digit count
  // is sized so that bit is always zero.
  assign shift_next = {bcd_adj, bin_reg} << 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      bin_reg   <= '0;
      bcd_reg   <= '0;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      valid_reg <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      bin_reg   <= bin_next;
      bcd_reg   <= bcd_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      valid_reg <= valid_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    bin_next   = bin_reg;
    bcd_next   = bcd_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    valid_next = valid_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          bin_next   = bin_in;
          bcd_next   = '0;
          cnt_next   = '0;
          busy_next  = 1'b1;
          state_next = CONVERT;
        end
      end

      CONVERT: begin
        bcd_next = shift_next[BCD_W+DATA_W-1:DATA_W];
        bin_next = shift_next[DATA_W-1:0];
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == CNT_W'(DATA_W - 1)) begin
          state_next = EMIT;
          idx_next   = IDX_W'(DIGITS - 1);
          valid_next = 1'b1;
        end
      end

      EMIT: begin
        if (valid_reg && digit_ready) begin
          if (idx_reg != '0) begin
            idx_next = idx_reg - 1'b1;
          end else begin
            valid_next = 1'b0;
            busy_next  = 1'b0;
            done_next  = 1'b1;
            state_next = IDLE;
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign busy        = busy_reg;
  assign bcd_out     = bcd_reg;
  assign digit_valid = valid_reg;
  assign digit_idx   = idx_reg;
  assign done        = done_reg;
  assign digit_out   = bcd_reg[int'(idx_reg)*DIGIT_W +: DIGIT_W];

endmodule

// File: tb/tb_bin2bcd_serial.sv
// Self-checking bench for bin2bcd_serial: directed cases, stalls, ignored
// restarts, back-to-back starts, asynchronous resets, an exhaustive sweep and
// random-ready runs, all against a decimal-arithmetic reference model.
module tb_bin2bcd_serial;

  localparam int DATA_W = 8;
  localparam int DIGITS = 3;
  localparam int IDX_W  = $clog2(DIGITS);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [DATA_W-1:0] bin_in = '0;
  logic              busy;
  logic [4*DIGITS-1:0] bcd_out;
  logic              digit_valid;
  logic              digit_ready = 1'b0;
  logic [3:0]        digit_out;
  logic [IDX_W-1:0]  digit_idx;
  logic              done;

  int vectors = 0;
  int miscompares = 0;

  bin2bcd_serial #(.DATA_W(DATA_W), .DIGITS(DIGITS)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .bin_in      (bin_in),
    .busy        (busy),
    .bcd_out     (bcd_out),
    .digit_valid (digit_valid),
    .digit_ready (digit_ready),
    .digit_out   (digit_out),
    .digit_idx   (digit_idx),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Reference: decimal digit i of v, by plain division.
  function automatic int ref_digit(input int v, input int i);
    int t = v;
    for (int k = 0; k < i; k++) t = t / 10;
    return t % 10;
  endfunction

  function automatic logic [31:0] ref_bcd(input int v);
    logic [31:0] r = '0;
    for (int i = 0; i < DIGITS; i++) r = r | (32'(ref_digit(v, i)) << (4 * i));
    return r;
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"},  32'(busy), 0);
    check({tag, "_valid"}, 32'(digit_valid), 0);
    check({tag, "_done"},  32'(done), 0);
    check({tag, "_dout"},  32'(digit_out), 0);
    check({tag, "_didx"},  32'(digit_idx), 0);
    check({tag, "_bcd"},   32'(bcd_out), 0);
  endtask

  // One conversion. Called at a negedge; start is accepted at the next posedge.
  // mode 0: ready=1, mode 1: ready pattern 0,0,1,0,1,1, mode 2: random ready.
  // b2b=1 returns in the done cycle so the caller can start immediately.
  task automatic convert(input int v, input int mode, input bit b2b);
    bit   pat [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    int   first_valid = -1;
    int   done_c = -1;
    int   busy_cnt = 0;
    int   p = 0;
    int   ndig = 0;
    bit   prev_stall = 1'b0;
    logic [3:0] prev_out = '0;
    logic [IDX_W-1:0] prev_idx = '0;
    string digs = "";

    start  = 1'b1;
    bin_in = DATA_W'(v);
    digit_ready = 1'($urandom % 2);
    @(posedge clk);
    #1;
    start  = 1'b0;
    bin_in = DATA_W'($urandom);

    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (done) begin
        done_c = c;
        break;
      end
      busy_cnt += int'(busy);
      if (prev_stall) begin
        check("stall_digit", 32'(digit_out), 32'(prev_out));
        check("stall_idx", 32'(digit_idx), 32'(prev_idx));
      end
      if (digit_valid && first_valid < 0) begin
        first_valid = c;
        check("bcd_out", 32'(bcd_out), ref_bcd(v));
      end
      if (digit_valid) begin
        case (mode)
          0:       digit_ready = 1'b1;
          1:       digit_ready = (p < 6) ? pat[p] : 1'b1;
          default: digit_ready = 1'($urandom % 2);
        endcase
        p++;
      end else begin
        digit_ready = 1'($urandom % 2);
      end
      // Starts while busy must be ignored.
      start  = busy && (c == 3 || ($urandom % 4) == 0);
      bin_in = start ? DATA_W'(99) : DATA_W'($urandom);
      if (digit_valid && digit_ready) begin
        if (ndig < DIGITS) begin
          check("digit", 32'(digit_out), 32'(ref_digit(v, DIGITS - 1 - ndig)));
          check("digit_idx", 32'(digit_idx), 32'(DIGITS - 1 - ndig));
          check("digit_le9", 32'(digit_out <= 4'd9), 1);
          digs = {digs, $sformatf("%0d", digit_out)};
        end else begin
          check("extra_digit", 32'(ndig), DIGITS - 1);
        end
        ndig++;
      end
      prev_stall = digit_valid && !digit_ready;
      prev_out   = digit_out;
      prev_idx   = digit_idx;
    end
    start = 1'b0;

    if (done_c < 0) check("timeout", 0, 1);
    check("latency", 32'(first_valid), DATA_W);
    check("ndigits", 32'(ndig), DIGITS);
    check("busy_at_done", 32'(busy), 0);
    check("valid_at_done", 32'(digit_valid), 0);
    check("busy_cycles", 32'(busy_cnt), 32'(done_c));
    if (mode == 0) check("done_cycle", 32'(done_c), DATA_W + DIGITS);
    $display("conv bin=%0d mode=%0d bcd=%h digits=%s done_at=%0d", v, mode, bcd_out, digs, done_c);
    if (!b2b) begin
      @(negedge clk);
      check("done_single", 32'(done), 0);
      check("idle_busy", 32'(busy), 0);
    end
  endtask

  task automatic watch_no_done(input string tag, input int n);
    int cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cnt += int'(done) + int'(busy);
    end
    check(tag, 32'(cnt), 0);
  endtask

  initial begin
    if (!(10.0 ** DIGITS > (2.0 ** DATA_W) - 1.0)) begin
      $display("FAIL param: DIGITS=%0d too small for DATA_W=%0d", DIGITS, DATA_W);
      $fatal(1);
    end

    repeat (2) @(negedge clk);
    check_reset_vals("por");
    rst_n = 1'b1;

    convert(255, 0, 0);
    convert(0, 0, 0);
    convert(100, 0, 0);
    convert(42, 1, 0);
    convert(42, 0, 1);
    convert(99, 0, 0);

    // Reset in the middle of CONVERT.
    start = 1'b1;
    bin_in = 8'd200;
    digit_ready = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("rst_conv");
    $display("reset asserted mid-convert");
    @(negedge clk);
    rst_n = 1'b1;
    watch_no_done("rst_conv_nodone", 20);

    // Reset in EMIT after one digit transfer.
    start = 1'b1;
    bin_in = 8'd255;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 20 && !digit_valid; i++) @(negedge clk);
    check("emit_reached", 32'(digit_valid), 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("rst_emit");
    $display("reset asserted mid-emit");
    @(negedge clk);
    rst_n = 1'b1;
    watch_no_done("rst_emit_nodone", 20);

    convert(7, 0, 0);

    for (int v = 0; v < 256; v++) convert(v, 0, 0);
    for (int n = 0; n < 30; n++) convert(int'($urandom_range(0, 255)), 2, 1'($urandom % 2));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
